// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// div_seq_pkg : shared state encoding and sizing helpers for the divider feeder
// Rev 1.0
// ============================================================================
package div_seq_pkg;

  localparam int OPERAND_W = 64;
  localparam int QUOT_W    = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [QUOT_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  function automatic int timeout_cnt_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

  function automatic int fifo_entry_w(input int tag_w);
    return 2 * OPERAND_W + tag_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_fifo.sv
`default_nettype none
// ============================================================================
// div_seq_fifo : synchronous operand FIFO, power-of-two depth, async low reset
// Rev 1.0
// ============================================================================
module div_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 132
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/div_operand_sequencer.sv
`default_nettype none
// ============================================================================
// div_operand_sequencer : buffers operand pairs, drives the divider one at a
// time and returns tagged quotients; screens divide-by-zero, traps a hung core.
// Rev 1.0
// ============================================================================
module div_operand_sequencer
  import div_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_dividend,
  input  logic [OPERAND_W-1:0] in_divisor,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 div_en,
  output logic [OPERAND_W-1:0] g_dividend_Q,
  output logic [OPERAND_W-1:0] g_divider_Q,
  input  logic [QUOT_W-1:0]    div_quotient,
  input  logic                 div_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUOT_W-1:0]    out_quotient,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_dbz,
  output logic                 timeout_err
);

  localparam int ENTRY_W = fifo_entry_w(TAG_W);
  localparam int CNT_W   = timeout_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYC);

  logic [1:0]           state_q, state_d;
  logic [OPERAND_W-1:0] dividend_q, dividend_d;
  logic [OPERAND_W-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [QUOT_W-1:0]    quot_q, quot_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 dbz_q, dbz_d;
  logic                 valid_q, valid_d;
  logic                 terr_q, terr_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic [OPERAND_W-1:0] head_dividend, head_divisor;
  logic [TAG_W-1:0]     head_tag;

  // in_ready is gated by reset so it reads 0 while the block is held in reset.
  assign in_ready  = reset && !fifo_full && !terr_q;
  assign fifo_push = in_valid && in_ready;

  div_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({in_tag, in_divisor, in_dividend}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_dividend = fifo_head[OPERAND_W-1:0];
  assign head_divisor  = fifo_head[2*OPERAND_W-1:OPERAND_W];
  assign head_tag      = fifo_head[ENTRY_W-1 -: TAG_W];

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    tag_d      = tag_q;
    dbz_d      = dbz_q;
    valid_d    = valid_q;
    terr_d     = terr_q;
    fifo_pop   = 1'b0;

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The quotient lives for one cycle only, so never start unless the
        // result register is already free to take it.
        if (!fifo_empty && !valid_q) begin
          if (head_divisor == '0) begin
            quot_d   = DBZ_QUOTIENT;
            dbz_d    = 1'b1;
            tag_d    = head_tag;
            valid_d  = 1'b1;
            fifo_pop = 1'b1;
          end else begin
            dividend_d = head_dividend;
            divisor_d  = head_divisor;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          quot_d   = div_quotient;
          tag_d    = head_tag;
          dbz_d    = 1'b0;
          valid_d  = 1'b1;
          fifo_pop = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_CNT) begin
            terr_d  = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      tag_q      <= '0;
      dbz_q      <= 1'b0;
      valid_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      tag_q      <= tag_d;
      dbz_q      <= dbz_d;
      valid_q    <= valid_d;
      terr_q     <= terr_d;
    end
  end

  assign div_en       = (state_q == S_ISSUE);
  assign g_dividend_Q = dividend_q;
  assign g_divider_Q  = divisor_q;
  assign out_valid    = valid_q;
  assign out_quotient = quot_q;
  assign out_tag      = tag_q;
  assign out_dbz      = dbz_q;
  assign timeout_err  = terr_q;

endmodule
`default_nettype wire
